// File: rtl/vga_timing_pkg.sv
// Shared raster constants and coordinate type for the VGA timing source and pattern blocks.
// Defaults describe 640x480@60; the timing generator can override them per instance.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_HSYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC;
  localparam int unsigned DEF_VSYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC;

  localparam int unsigned CENTER_X = DEF_H_ACTIVE / 2;
  localparam int unsigned CENTER_Y = DEF_V_ACTIVE / 2;

  // Half-open range test used by the sync decoders.
  function automatic logic in_range(coord_t v, int unsigned lo, int unsigned hi);
    return (v >= coord_t'(lo)) && (v < coord_t'(hi));
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable; exposes its next value so the parent can decode ahead.
// wrap_o is high in the enabled cycle where the count returns from N-1 to 0.
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned N = DEF_H_TOTAL
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ce_i,
  output coord_t count_o,
  output coord_t next_o,
  output logic   wrap_o
);

  if (N < 1 || N > (1 << COORD_W)) begin : g_bad_modulus
    $error("mod_counter: N=%0d does not fit a %0d-bit coordinate", N, COORD_W);
  end

  localparam coord_t Last = coord_t'(N - 1);

  coord_t count_q, count_d;

  assign wrap_o = ce_i && (count_q == Last);

  always_comb begin
    count_d = count_q;
    if (ce_i) begin
      count_d = wrap_o ? '0 : count_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: x/y counters plus registered sync, display-enable and frame strobe.
// Status flops load from the decode of the next (x,y), so they line up with the coordinates.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   pix_ce_i,
  output coord_t x_o,
  output coord_t y_o,
  output logic   display_on_o,
  output logic   hsync_o,
  output logic   vsync_o,
  output logic   next_frame_o
);

  localparam int unsigned HTotal  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsStart = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd   = HsStart + H_SYNC;
  localparam int unsigned VsStart = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd   = VsStart + V_SYNC;

  if (HTotal > 1024 || VTotal > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed 10-bit coordinates",
           HTotal, VTotal);
  end

  coord_t x_next, y_next;
  logic   h_wrap;
  logic   unused_v_wrap;

  mod_counter #(.N(HTotal)) u_h_cnt (
    .clk     (clk),
    .rst     (rst),
    .ce_i    (pix_ce_i),
    .count_o (x_o),
    .next_o  (x_next),
    .wrap_o  (h_wrap)
  );

  mod_counter #(.N(VTotal)) u_v_cnt (
    .clk     (clk),
    .rst     (rst),
    .ce_i    (h_wrap),
    .count_o (y_o),
    .next_o  (y_next),
    .wrap_o  (unused_v_wrap)
  );

  logic display_on_d, hsync_d, vsync_d, next_frame_d;
  logic display_on_q, hsync_q, vsync_q, next_frame_q;

  always_comb begin
    display_on_d = (x_next < coord_t'(H_ACTIVE)) && (y_next < coord_t'(V_ACTIVE));
    hsync_d      = in_range(x_next, HsStart, HsEnd) ? SYNC_POL : ~SYNC_POL;
    vsync_d      = in_range(y_next, VsStart, VsEnd) ? SYNC_POL : ~SYNC_POL;
    // h_wrap already implies pix_ce, so a stalled cycle at (0,V_ACTIVE) cannot re-fire.
    next_frame_d = h_wrap && (y_next == coord_t'(V_ACTIVE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_on_q <= 1'b1;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      next_frame_q <= 1'b0;
    end else begin
      next_frame_q <= next_frame_d;
      if (pix_ce_i) begin
        display_on_q <= display_on_d;
        hsync_q      <= hsync_d;
        vsync_q      <= vsync_d;
      end
    end
  end

  assign display_on_o = display_on_q;
  assign hsync_o      = hsync_q;
  assign vsync_o      = vsync_q;
  assign next_frame_o = next_frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: shrunken rasters (both sync polarities) plus the 640x480 default,
// scoreboarded every cycle against a reference raster model, with table and corner sequences.
module tb_vga_timing_gen;

  localparam int S_HA = 8, S_HFP = 2, S_HS = 3, S_HBP = 3;
  localparam int S_VA = 4, S_VFP = 2, S_VS = 2, S_VBP = 2;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;  // 16
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;  // 10
  localparam int D_HT = 800, D_VT = 525;

  typedef struct {
    int   x;
    int   y;
    logic de;
    logic hs;
    logic vs;
    logic nf;
  } exp_t;

  typedef struct {
    logic rst;
    int   mode;   // 0: pix_ce low, 1: pix_ce high, 2: alternate starting high
    int   cycles;
    int   ex;
    int   ey;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;

  logic [9:0] xs, ys, xp, yp, xd, yd;
  logic des, hss, vss, nfs_o;
  logic dep, hsp, vsp, nfp_o;
  logic ded, hsd, vsd, nfd_o;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_ce_i(pix_ce), .x_o(xs), .y_o(ys), .display_on_o(des),
    .hsync_o(hss), .vsync_o(vss), .next_frame_o(nfs_o)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SYNC_POL(1'b1)
  ) dut_p (
    .clk(clk), .rst(rst), .pix_ce_i(pix_ce), .x_o(xp), .y_o(yp), .display_on_o(dep),
    .hsync_o(hsp), .vsync_o(vsp), .next_frame_o(nfp_o)
  );

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .pix_ce_i(pix_ce), .x_o(xd), .y_o(yd), .display_on_o(ded),
    .hsync_o(hsd), .vsync_o(vsd), .next_frame_o(nfd_o)
  );

  int nerr = 0;
  int nchk = 0;
  int sx = 0, sy = 0, dx = 0, dy = 0;
  logic nf_s = 1'b0, nf_d = 1'b0;
  int nf_cnt = 0;
  int nf_de = 0;
  exp_t qs[$], qp[$], qd[$];
  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t decode(input int x, input int y, input int ha, input int hfp,
                                  input int hsw, input int va, input int vfp, input int vsw,
                                  input logic pol, input logic nf);
    exp_t d;
    d.x  = x;
    d.y  = y;
    d.de = (x < ha) && (y < va);
    d.hs = (x >= ha + hfp && x < ha + hfp + hsw) ? pol : ~pol;
    d.vs = (y >= va + vfp && y < va + vfp + vsw) ? pol : ~pol;
    d.nf = nf;
    return d;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                     input logic de, input logic hs, input logic vs, input logic nf);
    check({tag, ".x"}, int'(x), e.x);
    check({tag, ".y"}, int'(y), e.y);
    check({tag, ".display_on"}, int'(de), int'(e.de));
    check({tag, ".hsync"}, int'(hs), int'(e.hs));
    check({tag, ".vsync"}, int'(vs), int'(e.vs));
    check({tag, ".next_frame"}, int'(nf), int'(e.nf));
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare 1 time unit later.
  task automatic step(input logic r, input logic c);
    exp_t e;
    @(negedge clk);
    rst = r;
    pix_ce = c;
    @(posedge clk);
    if (r) begin
      sx = 0; sy = 0; dx = 0; dy = 0; nf_s = 1'b0; nf_d = 1'b0;
    end else if (c) begin
      if (sx == S_HT - 1) begin sx = 0; sy = (sy == S_VT - 1) ? 0 : sy + 1; end
      else sx++;
      if (dx == D_HT - 1) begin dx = 0; dy = (dy == D_VT - 1) ? 0 : dy + 1; end
      else dx++;
      nf_s = (sx == 0 && sy == S_VA);
      nf_d = (dx == 0 && dy == 480);
    end else begin
      nf_s = 1'b0; nf_d = 1'b0;
    end
    qs.push_back(decode(sx, sy, S_HA, S_HFP, S_HS, S_VA, S_VFP, S_VS, 1'b0, nf_s));
    qp.push_back(decode(sx, sy, S_HA, S_HFP, S_HS, S_VA, S_VFP, S_VS, 1'b1, nf_s));
    qd.push_back(decode(dx, dy, 640, 16, 96, 480, 10, 2, 1'b0, nf_d));
    #1;
    e = qs.pop_front();
    cmp("s", e, xs, ys, des, hss, vss, nfs_o);
    e = qp.pop_front();
    cmp("p", e, xp, yp, dep, hsp, vsp, nfp_o);
    e = qd.pop_front();
    cmp("d", e, xd, yd, ded, hsd, vsd, nfd_o);
    if (nfs_o) nf_cnt++;
    if (nfs_o && des) nf_de++;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1, 3, 0, 0};
    vecs[1] = '{1'b0, 1, 5, 5, 0};
    vecs[2] = '{1'b0, 0, 4, 5, 0};
    vecs[3] = '{1'b0, 1, 11, 0, 1};
    vecs[4] = '{1'b0, 1, 48, 0, 4};
    vecs[5] = '{1'b0, 1, 100, 4, 0};
    vecs[6] = '{1'b0, 2, 20, 14, 0};
    vecs[7] = '{1'b0, 1, 5, 3, 1};
    vecs[8] = '{1'b1, 1, 2, 0, 0};
    vecs[9] = '{1'b0, 1, 1000, 8, 2};

    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < vecs[i].cycles; k++) begin
        step(vecs[i].rst, (vecs[i].mode == 1) || (vecs[i].mode == 2 && k % 2 == 0));
      end
      check($sformatf("vec%0d.x", i), int'(xs), vecs[i].ex);
      check($sformatf("vec%0d.y", i), int'(ys), vecs[i].ey);
    end

    // One full frame at pix_ce=1: exactly one strobe.
    nf_cnt = 0;
    for (int k = 0; k < S_HT * S_VT; k++) step(1'b0, 1'b1);
    check("frame_ce1.pulses", nf_cnt, 1);

    // One frame at half rate: still one single-clock strobe.
    nf_cnt = 0;
    for (int k = 0; k < 2 * S_HT * S_VT; k++) step(1'b0, (k % 2) == 0);
    check("frame_ce_alt.pulses", nf_cnt, 1);
    check("frame_ce_alt.x", int'(xs), 8);
    check("frame_ce_alt.y", int'(ys), 2);
    check("default.x", int'(xd), 520);
    check("default.y", int'(yd), 1);
    check("nf_during_display", nf_de, 0);

    // Asynchronous reset mid-line: outputs must clear before any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async.x", int'(xs), 0);
    check("async.y", int'(ys), 0);
    check("async.display_on", int'(des), 1);
    check("async.hsync", int'(hss), 1);
    check("async.vsync", int'(vss), 1);
    check("async.hsync_pol1", int'(hsp), 0);
    check("async.x_default", int'(xd), 0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1);

    nf_cnt = 0;
    for (int k = 0; k < S_HT * S_VA - 1; k++) step(1'b0, 1'b1);
    check("post_rst.no_early_nf", nf_cnt, 0);
    check("post_rst.x", int'(xs), S_HT - 1);
    check("post_rst.y", int'(ys), S_VA - 1);
    step(1'b0, 1'b1);
    check("post_rst.first_nf", nf_cnt, 1);
    check("post_rst.y_va", int'(ys), S_VA);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
